regwrite_arbiter: RTL and testbench

Shares the register file's single write port between two writeback sources: the ALU result path (port A) and the load unit (port B). Each source uses a valid/ready handshake. The block grants at most one source per cycle using round-robin priority and drives a registered `wr_en`/`wr_reg`/`wr_data` triple straight into the register file's `write_en`/`wreg`/`writedata` inputs. An optional scoreboard tracks destination registers with writes still outstanding so the issue logic can stall on hazards.

---
 rtl/regwrite_arbiter_if.sv | 40 ++++
 rtl/regwrite_arbiter.sv | 122 ++++++++++++
 tb/tb_regwrite_arbiter.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/regwrite_arbiter_if.sv
// Writeback bus shared by the ALU/load sources, the arbiter and the register file.
// Also carries the issue-stage claim port and the hazard scoreboard view.
interface regwrite_arbiter_if #(
    parameter int unsigned DW = 16,
    parameter int unsigned AW = 3
);
    localparam int unsigned NREG = 1 << AW;

    logic            a_valid;
    logic [AW-1:0]   a_reg;
    logic [DW-1:0]   a_data;
    logic            a_ready;

    logic            b_valid;
    logic [AW-1:0]   b_reg;
    logic [DW-1:0]   b_data;
    logic            b_ready;

    logic            wr_en;
    logic [AW-1:0]   wr_reg;
    logic [DW-1:0]   wr_data;

    logic [15:0]     conflict_cnt;

    logic            claim_valid;
    logic [AW-1:0]   claim_reg;
    logic [NREG-1:0] pending;

    // Requesters, issue stage and register file side.
    modport master (
        output a_valid, a_reg, a_data, b_valid, b_reg, b_data, claim_valid, claim_reg,
        input  a_ready, b_ready, wr_en, wr_reg, wr_data, conflict_cnt, pending
    );

    // Arbiter side.
    modport slave (
        input  a_valid, a_reg, a_data, b_valid, b_reg, b_data, claim_valid, claim_reg,
        output a_ready, b_ready, wr_en, wr_reg, wr_data, conflict_cnt, pending
    );
endinterface

// File: rtl/regwrite_arbiter.sv
// Round-robin arbiter sharing the register file write port between the ALU (A)
// and the load unit (B). Optional destination scoreboard enabled by the macro
// REGARB_SCOREBOARD_EN; with it undefined, pending is tied to zero.
module regwrite_arbiter #(
    parameter int unsigned DW = 16,
    parameter int unsigned AW = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    regwrite_arbiter_if.slave  bus
);
    localparam int unsigned NREG = 1 << AW;
    localparam int unsigned CW   = 16;
    localparam logic [CW-1:0] CNT_MAX = '1;

    typedef enum logic {
        PRIO_A = 1'b0,
        PRIO_B = 1'b1
    } prio_e;

    prio_e           r_prio;
    prio_e           w_prio_next;
    logic            w_a_grant;
    logic            w_b_grant;

    logic            r_wr_en;
    logic [AW-1:0]   r_wr_reg;
    logic [DW-1:0]   r_wr_data;
    logic [CW-1:0]   r_conflict_cnt;

    // Priority register: A wins the first contested cycle after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prio <= PRIO_A;
        end else begin
            r_prio <= w_prio_next;
        end
    end

    // Grant decision and round-robin update; readies held low during reset.
    always_comb begin
        w_a_grant   = 1'b0;
        w_b_grant   = 1'b0;
        w_prio_next = r_prio;
        if (rst_n) begin
            if (bus.a_valid && (!bus.b_valid || r_prio == PRIO_A)) begin
                w_a_grant = 1'b1;
            end else if (bus.b_valid) begin
                w_b_grant = 1'b1;
            end
        end
        if (w_a_grant) begin
            w_prio_next = PRIO_B;
        end else if (w_b_grant) begin
            w_prio_next = PRIO_A;
        end
    end

    assign bus.a_ready = w_a_grant;
    assign bus.b_ready = w_b_grant;

    // Registered write triple and saturating contention counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_en        <= 1'b0;
            r_wr_reg       <= '0;
            r_wr_data      <= '0;
            r_conflict_cnt <= '0;
        end else begin
            r_wr_en <= w_a_grant | w_b_grant;
            if (w_a_grant) begin
                r_wr_reg  <= bus.a_reg;
                r_wr_data <= bus.a_data;
            end else if (w_b_grant) begin
                r_wr_reg  <= bus.b_reg;
                r_wr_data <= bus.b_data;
            end
            if (bus.a_valid && bus.b_valid && r_conflict_cnt != CNT_MAX) begin
                r_conflict_cnt <= r_conflict_cnt + CW'(1);
            end
        end
    end

    assign bus.wr_en        = r_wr_en;
    assign bus.wr_reg       = r_wr_reg;
    assign bus.wr_data      = r_wr_data;
    assign bus.conflict_cnt = r_conflict_cnt;

`ifdef REGARB_SCOREBOARD_EN
    logic [NREG-1:0] r_pending;
    logic [NREG-1:0] w_clr_mask;
    logic [NREG-1:0] w_set_mask;

    // Claim sets a bit, a completing write clears it; set applied last so it wins.
    always_comb begin
        w_clr_mask = '0;
        w_set_mask = '0;
        if (r_wr_en) begin
            w_clr_mask[r_wr_reg] = 1'b1;
        end
        if (bus.claim_valid) begin
            w_set_mask[bus.claim_reg] = 1'b1;
        end
    end

    // Outstanding-write scoreboard.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr_mask) | w_set_mask;
        end
    end

    assign bus.pending = r_pending;
`else
    logic w_unused_claim;
    assign w_unused_claim = ^{bus.claim_valid, bus.claim_reg};
    assign bus.pending    = '0;
`endif

endmodule

// File: tb/tb_regwrite_arbiter.sv
// Self-checking bench for regwrite_arbiter: directed scenarios plus randomized
// traffic, all compared against a transaction-level model of the grant rules.
module tb_regwrite_arbiter;
    localparam int unsigned DW   = 16;
    localparam int unsigned AW   = 3;
    localparam int unsigned NREG = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regwrite_arbiter_if #(.DW(DW), .AW(AW)) bus ();

    regwrite_arbiter #(.DW(DW), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Register file stub driven by the arbiter outputs.
    logic [DW-1:0] rf [NREG];
    always @(posedge clk) begin
        if (bus.wr_en) rf[bus.wr_reg] <= bus.wr_data;
    end

    // Model state: what the write port and counters must show.
    logic            m_last_b;   // 1 when B was the most recent winner (or after reset)
    logic            m_wr_en;
    logic [AW-1:0]   m_wr_reg;
    logic [DW-1:0]   m_wr_data;
    int              m_cnt;
    logic [NREG-1:0] m_pend;
    logic            g_a, g_b;   // grants the model expected in the last step

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic av, input logic [AW-1:0] ar, input logic [DW-1:0] ad,
                          input logic bv, input logic [AW-1:0] br, input logic [DW-1:0] bd,
                          input logic cv, input logic [AW-1:0] cr);
        bus.a_valid = av; bus.a_reg = ar; bus.a_data = ad;
        bus.b_valid = bv; bus.b_reg = br; bus.b_data = bd;
        bus.claim_valid = cv; bus.claim_reg = cr;
    endtask

    // One clock: check readies against the rules, advance the model, check registered outputs.
    task automatic step();
        logic            ga, gb, n_en, n_last;
        logic [AW-1:0]   n_reg;
        logic [DW-1:0]   n_data;
        int              n_cnt;
        logic [NREG-1:0] n_pend;
        #1;
        ga = rst_n && bus.a_valid && (!bus.b_valid || m_last_b);
        gb = rst_n && bus.b_valid && !ga;
        chk("a_ready", 32'(bus.a_ready), 32'(ga));
        chk("b_ready", 32'(bus.b_ready), 32'(gb));
        g_a = ga;
        g_b = gb;
        if (!rst_n) begin
            n_en = 1'b0; n_reg = '0; n_data = '0; n_cnt = 0; n_pend = '0; n_last = 1'b1;
        end else begin
            n_en   = ga | gb;
            n_reg  = ga ? bus.a_reg  : (gb ? bus.b_reg  : m_wr_reg);
            n_data = ga ? bus.a_data : (gb ? bus.b_data : m_wr_data);
            n_last = ga ? 1'b0 : (gb ? 1'b1 : m_last_b);
            n_cnt  = (bus.a_valid && bus.b_valid && m_cnt < 65535) ? m_cnt + 1 : m_cnt;
            n_pend = m_pend;
`ifdef REGARB_SCOREBOARD_EN
            if (m_wr_en) n_pend[m_wr_reg] = 1'b0;
            if (bus.claim_valid) n_pend[bus.claim_reg] = 1'b1;
`endif
        end
        @(posedge clk);
        #1;
        m_wr_en = n_en; m_wr_reg = n_reg; m_wr_data = n_data;
        m_cnt = n_cnt; m_pend = n_pend; m_last_b = n_last;
        chk("wr_en",        32'(bus.wr_en),        32'(m_wr_en));
        chk("wr_reg",       32'(bus.wr_reg),       32'(m_wr_reg));
        chk("wr_data",      32'(bus.wr_data),      32'(m_wr_data));
        chk("conflict_cnt", 32'(bus.conflict_cnt), 32'(m_cnt));
        chk("pending",      32'(bus.pending),      32'(m_pend));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_in(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
        step();
        step();
        rst_n = 1'b1;
    endtask

    logic            a_v, b_v;
    logic [AW-1:0]   a_r, b_r;
    logic [DW-1:0]   a_d, b_d;
    logic [AW-1:0]   seq [4];
    logic [AW-1:0]   exp_seq [4];

    initial begin
        exp_seq[0] = 3'd1; exp_seq[1] = 3'd2; exp_seq[2] = 3'd1; exp_seq[3] = 3'd2;
        set_in(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
        @(posedge clk);
        #1;

        // Reset state and single ALU write.
        do_reset();
        chk("rst_wr_en",   32'(bus.wr_en), 32'h0);
        chk("rst_wr_reg",  32'(bus.wr_reg), 32'h0);
        chk("rst_wr_data", 32'(bus.wr_data), 32'h0);
        chk("rst_cnt",     32'(bus.conflict_cnt), 32'h0);
        chk("rst_pending", 32'(bus.pending), 32'h0);
        set_in(1'b1, 3'd3, 16'h1234, 1'b0, '0, '0, 1'b0, '0);
        #1;
        chk("t1_a_ready", 32'(bus.a_ready), 32'h1);
        step();
        chk("t1_wr_en",   32'(bus.wr_en), 32'h1);
        chk("t1_wr_reg",  32'(bus.wr_reg), 32'h3);
        chk("t1_wr_data", 32'(bus.wr_data), 32'h1234);
        set_in(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
        step();
        chk("t1_rf3", 32'(rf[3]), 32'h1234);

        // Continuous contention alternates A,B,A,B.
        do_reset();
        set_in(1'b1, 3'd1, 16'h00AA, 1'b1, 3'd2, 16'h00BB, 1'b0, '0);
        for (int i = 0; i < 4; i++) begin
            step();
            seq[i] = bus.wr_reg;
        end
        for (int i = 0; i < 4; i++) chk("t2_wr_reg_seq", 32'(seq[i]), 32'(exp_seq[i]));
        chk("t2_cnt", 32'(bus.conflict_cnt), 32'd4);

        // Same destination: A first, B last, B's value persists.
        do_reset();
        set_in(1'b1, 3'd5, 16'h0001, 1'b1, 3'd5, 16'h0002, 1'b0, '0);
        step();
        chk("t3_first", 32'(bus.wr_data), 32'h0001);
        set_in(1'b0, '0, '0, 1'b1, 3'd5, 16'h0002, 1'b0, '0);
        step();
        chk("t3_second", 32'(bus.wr_data), 32'h0002);
        set_in(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
        step();
        chk("t3_rf5", 32'(rf[5]), 32'h0002);

        // Reset arriving with a live request drops it and restores A priority.
        set_in(1'b1, 3'd6, 16'h0066, 1'b1, 3'd7, 16'h0077, 1'b0, '0);
        step();
        rst_n = 1'b0;
        step();
        chk("t4_wr_en", 32'(bus.wr_en), 32'h0);
        chk("t4_cnt",   32'(bus.conflict_cnt), 32'h0);
        rst_n = 1'b1;
        step();
        chk("t4_a_first", 32'(bus.wr_reg), 32'h6);

        // Saturation of the contention counter.
        do_reset();
        set_in(1'b1, 3'd1, 16'h1111, 1'b1, 3'd2, 16'h2222, 1'b0, '0);
        for (int i = 0; i < 65540; i++) step();
        chk("t5_sat", 32'(bus.conflict_cnt), 32'hFFFF);

        // Scoreboard claim/clear behaviour.
        do_reset();
        set_in(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 3'd4);
        step();
`ifdef REGARB_SCOREBOARD_EN
        chk("t6_claim", 32'(bus.pending), 32'h10);
`else
        chk("t6_claim", 32'(bus.pending), 32'h00);
`endif
        set_in(1'b0, '0, '0, 1'b1, 3'd4, 16'h4444, 1'b0, '0);
        step();
        set_in(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
        step();
        chk("t6_clear", 32'(bus.pending), 32'h00);
        set_in(1'b0, '0, '0, 1'b1, 3'd4, 16'h4545, 1'b1, 3'd4);
        step();
        set_in(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 3'd4);
        step();
`ifdef REGARB_SCOREBOARD_EN
        chk("t6_set_wins", 32'(bus.pending), 32'h10);
`else
        chk("t6_set_wins", 32'(bus.pending), 32'h00);
`endif
        set_in(1'b0, '0, '0, 1'b1, 3'd4, 16'h4646, 1'b1, 3'd2);
        step();
        set_in(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
        step();
`ifdef REGARB_SCOREBOARD_EN
        chk("t6_diff_regs", 32'(bus.pending), 32'h04);
`else
        chk("t6_diff_regs", 32'(bus.pending), 32'h00);
`endif

        // Random traffic; sources hold their request until accepted.
        do_reset();
        a_v = 1'b0; b_v = 1'b0; a_r = '0; b_r = '0; a_d = '0; b_d = '0;
        for (int i = 0; i < 600; i++) begin
            if (!a_v && $urandom_range(0, 2) != 0) begin
                a_v = 1'b1; a_r = AW'($urandom); a_d = DW'($urandom);
            end
            if (!b_v && $urandom_range(0, 2) != 0) begin
                b_v = 1'b1; b_r = AW'($urandom); b_d = DW'($urandom);
            end
            rst_n = ($urandom_range(0, 49) != 0);
            set_in(a_v, a_r, a_d, b_v, b_r, b_d, 1'($urandom_range(0, 1)), AW'($urandom));
            step();
            if (g_a) a_v = 1'b0;
            if (g_b) b_v = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
